// File: rtl/approx_mult_pkg.sv
// Shared types for the approximate-multiplier datapath and its result FIFO.
package approx_mult_pkg;

  localparam int RESULT_W = 16;

  typedef logic [RESULT_W-1:0] result_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
// Storage is not reset; validity of each entry is tracked by the owning FIFO.
module sync_fifo_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the addressed entry when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mult_result_fifo.sv
// Result FIFO behind the approximate multiplier: captures mult_result on done_in,
// queues DEPTH entries, and hands them to the consumer over valid/ready.
// Optional macro MULT_FIFO_OVF_FLAG_EN builds a sticky overflow flag on ovf;
// without it ovf is tied to 0.
module mult_result_fifo
  import approx_mult_pkg::*;
#(
  parameter int DATA_W = RESULT_W,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    done_in,
  input  logic [DATA_W-1:0]       result_in,
  output logic                    full,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  // Handshake: the head entry transfers on a cycle where out_valid and out_ready
  // are both high; out_valid never depends on out_ready, and out_ready is ignored
  // while out_valid is low. done_in is a one-cycle strobe with no ready: a strobe
  // arriving while full without a same-cycle pop is dropped.

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count_q;
  logic [PTR_W:0]    count_next;
  logic [DATA_W-1:0] head_data;
  logic              push;
  logic              pop;

  assign full      = (count_q == CNT_DEPTH);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign push      = done_in & (~full | pop);
  assign out_data  = out_valid ? head_data : '0;
  assign count     = count_q;

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (result_in),
    .raddr (rd_ptr),
    .rdata (head_data)
  );

  // Occupancy follows push/pop; a simultaneous pair leaves it unchanged.
  always_comb begin
    count_next = count_q;
    if (push && !pop) begin
      count_next = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_next = count_q - CNT_ONE;
    end
  end

  // Pointer and occupancy registers; pointers wrap naturally at PTR_W bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count_q <= count_next;
    end
  end

`ifdef MULT_FIFO_OVF_FLAG_EN
  logic drop;
  logic ovf_q;

  assign drop = done_in & full & ~pop;

  // Sticky record of a dropped result; cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
